// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one byte-wide UART transmitter among NUM_REQ
// packet sources. A grant lasts a whole packet, or until the owner stalls too long.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      tx_busy,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      timeout
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               tx_start_q, tx_start_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               last_q, last_d;

  logic [DATA_W-1:0]  req_bytes [NUM_REQ];
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic               accept;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // First requesting index after the last-served pointer, wrapping around.
  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = PTR_W'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign req_ready = (state_q == SEND && !tx_busy) ? (grant_q & req_valid) : '0;
  assign accept    = |req_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = win_idx;
          state_d          = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          tx_data_d  = req_bytes[gidx_q];
          tx_start_d = 1'b1;
          last_d     = req_last[gidx_q];
          hold_cnt_d = '0;
          state_d    = WAIT_BUSY;
        end else if (!req_valid[gidx_q]) begin
          // Revoke exactly when the stall count reaches the limit, so no saturation.
          if (hold_cnt_q == CNT_LAST) begin
            grant_d    = '0;
            ptr_d      = gidx_q;
            timeout_d  = 1'b1;
            hold_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            ptr_d   = gidx_q;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_RST;
      gidx_q     <= '0;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
    end
  end

  assign grant    = grant_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet sources, a busy-for-N-cycles transmitter and a
// packet/frame lifecycle reference model checked every cycle, plus directed scenarios.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int HT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_busy;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic [N-1:0]    grant;
  logic            timeout;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .HOLD_TIMEOUT(HT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the transmitter and where the current frame is.
  int            ptr_m, owner_m, stall_m;
  bit            fr_active, fr_busy_seen, fr_last;
  logic [N-1:0]  exp_grant;
  logic          exp_start, exp_timeout;
  logic [DW-1:0] exp_data;

  // Environment: packet sources and the transmitter.
  logic [DW:0] src_mem [N][64];
  int          src_rd [N];
  int          src_wr [N];
  int          src_stall [N];
  int          stall_max, busy_left, busy_len;
  bit          ext_busy, rand_busy, ready2_while1;

  int            accepted_cnt, start_cnt, timeout_cnt;
  int            grant_log [$];
  logic [DW-1:0] tx_log [$];
  logic [N-1:0]  grant_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N] === 1'b1) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i] === 1'b1) return i;
    return -1;
  endfunction

  task automatic model_reset();
    ptr_m = N - 1; owner_m = -1; stall_m = 0;
    fr_active = 0; fr_busy_seen = 0; fr_last = 0;
    exp_grant = '0; exp_start = 0; exp_timeout = 0; exp_data = '0;
    busy_left = 0; grant_prev = '0;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      src_rd[i] = 0; src_wr[i] = 0; src_stall[i] = 0;
    end
  endtask

  task automatic push(input int i, input logic last, input logic [DW-1:0] b);
    src_mem[i][src_wr[i]] = {last, b};
    src_wr[i]++;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check ready, advance model.
  task automatic step();
    logic [N-1:0]    v, l, exp_ready;
    logic [N*DW-1:0] d;
    logic [DW:0]     e;
    int              w;
    @(negedge clk);
    check("grant", grant, exp_grant);
    check("tx_start", tx_start, exp_start);
    check("tx_data", tx_data, exp_data);
    check("timeout", timeout, exp_timeout);
    if (tx_start === 1'b1) begin
      start_cnt++;
      tx_log.push_back(tx_data);
    end
    if (timeout === 1'b1) timeout_cnt++;
    if (grant_prev == '0 && grant != '0) grant_log.push_back(onehot_idx(grant));
    grant_prev = grant;

    if (tx_start === 1'b1) begin
      busy_left = busy_len;
      if (rand_busy) busy_len = $urandom_range(1, 5);
    end else if (busy_left > 0) begin
      busy_left--;
    end
    tx_busy = (busy_left > 0) || ext_busy;

    for (int i = 0; i < N; i++) begin
      if (src_rd[i] != src_wr[i] && src_stall[i] == 0) begin
        e = src_mem[i][src_rd[i]];
        v[i] = 1'b1; l[i] = e[DW]; d[i*DW +: DW] = e[DW-1:0];
      end else begin
        v[i] = 1'b0; l[i] = 1'($urandom); d[i*DW +: DW] = DW'($urandom);
        if (src_stall[i] > 0) src_stall[i]--;
      end
    end
    req_valid = v; req_last = l; req_data = d;
    #1;
    exp_ready = '0;
    if (owner_m >= 0 && !fr_active && v[owner_m] && !tx_busy) exp_ready[owner_m] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    if (owner_m == 1 && req_ready[2] === 1'b1) ready2_while1 = 1;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] === 1'b1 && src_rd[i] != src_wr[i]) begin
        src_rd[i]++;
        src_stall[i] = $urandom_range(0, stall_max);
        accepted_cnt++;
      end
    end

    exp_start = 0; exp_timeout = 0;
    if (owner_m < 0) begin
      w = rr_pick(ptr_m, v);
      if (w >= 0) begin owner_m = w; stall_m = 0; end
    end else if (!fr_active) begin
      if (exp_ready != '0) begin
        exp_start = 1; exp_data = d[owner_m*DW +: DW];
        fr_active = 1; fr_busy_seen = 0; fr_last = l[owner_m]; stall_m = 0;
      end else if (!v[owner_m]) begin
        stall_m++;
        if (stall_m == HT) begin
          exp_timeout = 1; ptr_m = owner_m; owner_m = -1; stall_m = 0;
        end
      end
    end else if (!fr_busy_seen) begin
      if (tx_busy) fr_busy_seen = 1;
    end else if (!tx_busy) begin
      fr_active = 0;
      if (fr_last) begin ptr_m = owner_m; owner_m = -1; end
    end
    exp_grant = '0;
    if (owner_m >= 0) exp_grant[owner_m] = 1'b1;
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (src_rd[i] != src_wr[i]) return 0;
    return owner_m < 0 && !fr_active && busy_left == 0;
  endfunction

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while (!all_done() && n < bound) begin step(); n++; end
    check({tag, "_done"}, 32'(all_done()), 1);
    step(); step();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = '0; tx_busy = 1'b0; ext_busy = 0;
    #1;
    model_reset();
    clear_sources();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int t0, a0, len;
    rst = 1'b0; req_valid = '1; req_data = '0; req_last = '0; tx_busy = 1'b0;
    ext_busy = 0; rand_busy = 0; busy_len = 10; stall_max = 0; ready2_while1 = 0;
    accepted_cnt = 0; start_cnt = 0; timeout_cnt = 0;
    model_reset();
    clear_sources();
    repeat (3) @(negedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_timeout", timeout, 0);
    check("rst_req_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    // 1: single 3-byte packet on requester 2, 10-cycle frames
    push(2, 0, 8'h11); push(2, 0, 8'h22); push(2, 1, 8'h33);
    drain("t1", 400);
    check("t1_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) check("t1_owner", grant_log[0], 2);
    check("t1_starts", tx_log.size(), 3);
    for (int k = 0; k < tx_log.size() && k < 3; k++)
      check("t1_byte", tx_log[k], 32'h11 * (k + 1));

    // 2: all four stream 1-byte packets after reset
    apply_reset();
    busy_len = 2; grant_log.delete();
    for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) push(i, 1, 8'(16 * i + r));
    drain("t2", 400);
    check("t2_grants", grant_log.size(), 12);
    for (int k = 0; k < grant_log.size() && k < 12; k++) check("t2_order", grant_log[k], k % N);

    // 3: requester 1 mid-packet while requester 2 waits
    grant_log.delete(); stall_max = 3; busy_len = 3; ready2_while1 = 0;
    push(1, 0, 8'hA1); push(1, 0, 8'hA2); push(1, 1, 8'hA3); push(2, 1, 8'hB1);
    drain("t3", 400);
    check("t3_ready2_blocked", 32'(ready2_while1), 0);
    check("t3_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t3_first", grant_log[0], 1);
      check("t3_second", grant_log[1], 2);
    end

    // 4: requester 0 stalls after a non-last byte -> timeout, then requester 1 first
    grant_log.delete(); stall_max = 0; busy_len = 2; t0 = timeout_cnt;
    push(0, 0, 8'hC0);
    repeat (6) step();
    push(1, 1, 8'hC1); push(3, 1, 8'hC3);
    drain("t4", 400);
    check("t4_timeouts", timeout_cnt - t0, 1);
    check("t4_grants", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("t4_first", grant_log[0], 0);
      check("t4_after_timeout", grant_log[1], 1);
      check("t4_third", grant_log[2], 3);
    end

    // 5: transmitter held busy externally while a byte is offered
    t0 = start_cnt; a0 = accepted_cnt; ext_busy = 1;
    push(3, 1, 8'hD3);
    repeat (10) step();
    check("t5_no_start", start_cnt - t0, 0);
    check("t5_no_accept", accepted_cnt - a0, 0);
    ext_busy = 0;
    drain("t5", 200);
    check("t5_start_after", start_cnt - t0, 1);

    // 6: reset while a frame is in progress
    busy_len = 6;
    for (int i = 0; i < N; i++) begin push(i, 0, 8'(8'hE0 + i)); push(i, 1, 8'(8'hF0 + i)); end
    for (int n = 0; n < 100 && !(fr_active && fr_busy_seen); n++) step();
    step();
    check("t6_in_frame", 32'(fr_active && busy_left > 0), 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_grant", grant, 0);
    check("t6_tx_start", tx_start, 0);
    check("t6_tx_data", tx_data, 0);
    check("t6_timeout", timeout, 0);
    check("t6_req_ready", req_ready, 0);
    req_valid = '0; tx_busy = 1'b0;
    model_reset();
    clear_sources();
    @(negedge clk);
    rst = 1'b1;
    grant_log.delete();
    for (int i = 0; i < N; i++) push(i, 1, 8'(8'h50 + i));
    drain("t6", 200);
    check("t6_grants", grant_log.size(), 4);
    for (int k = 0; k < grant_log.size() && k < 4; k++) check("t6_order", grant_log[k], k);

    // 7: random packets, random stalls and frame lengths
    stall_max = 3; rand_busy = 1; busy_len = 3;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 6; p++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) push(i, 1'(b == len - 1), DW'($urandom));
      end
    end
    drain("t7", 4000);
    check("bytes_conserved", start_cnt, accepted_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
